alu16_mul_sequencer: RTL and testbench
======================================

# alu16_mul_sequencer

Multi-cycle controller that computes an unsigned 16x16 to 32-bit product by sequencing the shared 16-bit ALU through one shift-and-add iteration per clock. It sits beside the 16-bit ALU. It owns the ALU input ports while it runs and takes the ALU's combinational result back each cycle. Requesters use a start/busy/done handshake, and the product is held in a register until the next completion.

## Interface
Parameters:
- none; widths are fixed to match the 16-bit ALU.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- mcand  in  16  multiplicand; captured on the accepting edge.
- mplier  in  16  multiplier; captured on the accepting edge.
- busy  out  1  high from the accepting edge until return to IDLE.
- done  out  1  one-cycle pulse; product is valid when high.
- product  out  32  result register; holds until the next completion.
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_sel  out  4  ALU Select.
- alu_mode  out  1  ALU Mode.
- alu_cin  out  1  ALU cin.
- alu_f  in  16  ALU result F.
- alu_cout  in  1  ALU carry-out pin (inverted sense, see below).

## Operation
- ALU add convention: Mode=0, Select=9, cin=1 gives F = A + B with carry-in 0. The true carry-out is ~alu_cout.
- The block always drives alu_mode=0, alu_sel=9, alu_cin=1.
- Internal registers:
  - hi[15:0] and lo[15:0] (running product).
  - mc[15:0] (latched multiplicand).
  - cnt[3:0] (iteration counter).
  - state (IDLE, RUN, DONE).
- IDLE:
  - alu_a=0, alu_b=0.
  - On start=1: hi<=0, lo<=mplier, mc<=mcand, cnt<=0, state<=RUN.
- RUN, one iteration per cycle:
  - alu_a=hi.
  - alu_b = lo[0] ? mc : 16'h0000.
  - c = ~alu_cout.
  - {hi,lo} <= {c, alu_f, lo[15:1]}, i.e. a 33-bit right shift of {c, sum, lo}.
  - cnt<=cnt+1.
  - When cnt==15 (16th iteration): product <= {c, alu_f, lo[15:1]}, state<=DONE.
- DONE:
  - alu_a=0, alu_b=0.
  - done=1.
  - state<=IDLE unconditionally.
- start is ignored in RUN and DONE; it is not queued. A start held high through DONE is accepted on the first IDLE edge.
- mcand and mplier are don't-care except on the accepting edge.
- Arithmetic is unsigned. The 32-bit product cannot overflow: 0xFFFF*0xFFFF = 0xFFFE0001.
- Zero operands still take the full 16 iterations; there is no early termination.

## Timing
- Reset (async assert, any state, including mid-RUN):
  - state=IDLE, busy=0, done=0, product=0.
  - hi=lo=mc=0, cnt=0.
  - The ALU drive outputs take their IDLE values immediately.
  - Deassertion is synchronous-safe; the first active edge after release is an IDLE edge.
- Edge E0: start accepted in IDLE; busy=1 after E0.
- Edges E1..E16: 16 RUN iterations; product updates and done rises after E16.
- Edge E17: DONE to IDLE; done=0, busy=0.
- Latency: done is high in the 17th cycle after the accepting edge, for exactly one cycle.
- Minimum start-to-start spacing is 18 edges (E0 to the next acceptance at E18).
- busy and done are registered outputs. The alu_* outputs are decoded from registered state (no path from start).
- The ALU path (alu_a/alu_b out, alu_f/alu_cout in) is combinational within one cycle; the adder's critical path must fit the clock period.

## Test plan
- Basic multiply: mcand=3, mplier=5, start pulse.
  - done after exactly 17 cycles, product=0x0000000F, busy high for 17 cycles.
- Full-scale carry: mcand=0xFFFF, mplier=0xFFFF.
  - product=0xFFFE0001; checks use of ~alu_cout as the carry.
- Zero and identity:
  - 0x0000 * 0x1234 gives product=0, done still at cycle 17.
  - 0x0001 * 0xABCD gives 0x0000ABCD.
- Busy rejection:
  - start=1 continuously with changing operands: only the values at each IDLE acceptance are used.
  - Results appear every 18 cycles, with 0x00FF*0x0100 = 0x0000FF00 on the first.
- Reset mid-operation:
  - Assert rst_n=0 at iteration 8 of 0x1234*0x5678: busy, done and product go to 0 immediately, no done pulse.
  - After release, a new 0x1234*0x5678 gives 0x06260060.
- Product hold:
  - After completion, operands and ALU-input noise while IDLE leave product unchanged until the next done.

Source files
------------

// File: rtl/alu16_mul_sequencer.sv
// Unsigned 16x16->32 shift-and-add multiplier that borrows the shared 16-bit ALU, one iteration per clock.
// Done pulses in the 17th cycle after acceptance; start is ignored (not queued) while busy.
module alu16_mul_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] mcand,
  input  logic [15:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_sel,
  output logic        alu_mode,
  output logic        alu_cin,
  input  logic [15:0] alu_f,
  input  logic        alu_cout
);

  localparam logic [3:0] ALU_SEL_ADD = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] hi_q;
  logic [15:0] lo_q;
  logic [15:0] mc_q;
  logic [3:0]  cnt_q;
  logic [31:0] product_q;
  logic        busy_q;
  logic        done_q;

  logic        carry;
  logic [31:0] acc_d;

  // The ALU reports carry-out inverted; the shifted accumulator keeps the true carry as its MSB.
  assign carry = ~alu_cout;
  assign acc_d = {carry, alu_f, lo_q[15:1]};

  always_comb begin
    alu_a = 16'h0000;
    alu_b = 16'h0000;
    if (state_q == ST_RUN) begin
      alu_a = hi_q;
      alu_b = lo_q[0] ? mc_q : 16'h0000;
    end
  end

  assign alu_sel  = ALU_SEL_ADD;
  assign alu_mode = 1'b0;
  assign alu_cin  = 1'b1;

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hi_q      <= 16'h0000;
      lo_q      <= 16'h0000;
      mc_q      <= 16'h0000;
      cnt_q     <= 4'd0;
      product_q <= 32'h0000_0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            hi_q    <= 16'h0000;
            lo_q    <= mplier;
            mc_q    <= mcand;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          hi_q  <= acc_d[31:16];
          lo_q  <= acc_d[15:0];
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            product_q <= acc_d;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_mul_sequencer.sv
// Bench for alu16_mul_sequencer: behavioural 16-bit ALU beside the DUT, products predicted with plain a*b.
module tb_alu16_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_sel;
  logic        alu_mode;
  logic        alu_cin;
  logic [15:0] alu_f;
  logic        alu_cout;

  logic        noise_en;
  logic [16:0] noise;
  logic [16:0] alu_sum;

  int errs;
  int checks;

  alu16_mul_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mcand   (mcand),
    .mplier  (mplier),
    .busy    (busy),
    .done    (done),
    .product (product),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_mode(alu_mode),
    .alu_cin (alu_cin),
    .alu_f   (alu_f),
    .alu_cout(alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: add with carry-in 0 when Mode=0/Select=9/cin=1, carry pin inverted; anything else gives junk.
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
  always_comb begin
    alu_f    = alu_a ^ alu_b;
    alu_cout = 1'b1;
    if (noise_en) begin
      alu_f    = noise[15:0];
      alu_cout = noise[16];
    end else if (alu_mode == 1'b0 && alu_sel == 4'd9 && alu_cin == 1'b1) begin
      alu_f    = alu_sum[15:0];
      alu_cout = ~alu_sum[16];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [31:0] exp;
    int lat;
    int busy_n;
    exp = 32'(a) * 32'(b);
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = 16'($urandom);
    mplier = 16'($urandom);
    lat    = 0;
    busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd17);
    chk({tag, "_prod"}, product, exp);
    chk({tag, "_busy_cyc"}, 32'(busy_n), 32'd17);
    chk({tag, "_alu_ctl"}, {26'd0, alu_sel, alu_mode, alu_cin}, {26'd0, 4'd9, 1'b0, 1'b1});
    @(negedge clk);
    chk({tag, "_post"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_hold"}, product, exp);
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] held;
    logic [15:0] ra;
    logic [15:0] rb;
    int changed;
    int done_seen;

    errs     = 0;
    checks   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    mcand    = 16'h0;
    mplier   = 16'h0;
    noise_en = 1'b0;
    noise    = 17'h0;

    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", product, 32'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_mul(16'd3, 16'd5, "basic");
    run_mul(16'hFFFF, 16'hFFFF, "full");
    chk("full_const", product, 32'hFFFE_0001);
    run_mul(16'h0000, 16'h1234, "zero");
    run_mul(16'h0001, 16'hABCD, "ident");
    chk("ident_const", product, 32'h0000_ABCD);

    // start held high: only operands present at the IDLE acceptance edges (every 18th) matter
    for (int m = 0; m <= 54; m++) begin
      @(negedge clk);
      if (m > 0) begin
        chk($sformatf("rej_done_%0d", m), 32'(done), 32'((m % 18) == 17));
        if ((m % 18) == 17 && exp_q.size() > 0)
          chk($sformatf("rej_prod_%0d", m), product, exp_q.pop_front());
      end
      if (m == 54) begin
        start = 1'b0;
      end else begin
        start  = 1'b1;
        mcand  = (m == 0) ? 16'h00FF : 16'($urandom);
        mplier = (m == 0) ? 16'h0100 : 16'($urandom);
        if ((m % 18) == 0) exp_q.push_back(32'(mcand) * 32'(mplier));
      end
    end
    @(negedge clk);
    chk("rej_idle", 32'(busy), 32'd0);

    // reset at iteration 8 of a live multiply
    start  = 1'b1;
    mcand  = 16'h1234;
    mplier = 16'h5678;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {busy, done, product}, 34'd0);
    chk("mid_rst_alu", {alu_a, alu_b}, 32'd0);
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("mid_no_done", 32'(done_seen), 32'd0);
    run_mul(16'h1234, 16'h5678, "after_rst");
    chk("after_rst_const", product, 32'h0626_0060);

    // product hold while idle with operand and ALU noise
    held     = product;
    changed  = 0;
    noise_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      mcand  = 16'($urandom);
      mplier = 16'($urandom);
      noise  = 17'($urandom);
      if (product !== held || done) changed++;
    end
    noise_en = 1'b0;
    chk("hold_noise", 32'(changed), 32'd0);

    for (int k = 0; k < 25; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k == 0) rb = 16'h0000;
      if (k == 1) ra = 16'h8000;
      if (k == 2) rb = 16'hFFFF;
      run_mul(ra, rb, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
